// File: rtl/network_torus_if.sv
// Per-node handshake bundle between the traffic nodes and network_torus.
// master = node side (injects, applies ejection hold); slave = network side.
interface network_torus_if #(
  parameter int NODES = 9,
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] networkToNodeData         [NODES];
  logic             networkToNodeWriteRequest [NODES];
  logic             networkToNodeHoldRequest  [NODES];
  logic [WIDTH-1:0] nodeToNetworkData         [NODES];
  logic             nodeToNetworkWriteRequest [NODES];
  logic             nodeToNetworkHoldRequest  [NODES];

  modport master (
    output nodeToNetworkData, nodeToNetworkWriteRequest, nodeToNetworkHoldRequest,
    input  networkToNodeData, networkToNodeWriteRequest, networkToNodeHoldRequest
  );

  modport slave (
    input  nodeToNetworkData, nodeToNetworkWriteRequest, nodeToNetworkHoldRequest,
    output networkToNodeData, networkToNodeWriteRequest, networkToNodeHoldRequest
  );
endinterface

// File: rtl/network_torus.sv
// 2D torus/mesh of single-flit routers: five input FIFOs per router, X-then-Y routing
// (shortest way round on the torus) and a round-robin arbiter on each of the five outputs.
module network_torus #(
  parameter int X_NODES    = 3,
  parameter int Y_NODES    = 3,
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = 1
) (
  input  logic           clk,
  input  logic           reset,
  network_torus_if.slave bus
);
  localparam int NODES = X_NODES * Y_NODES;
  localparam int PORTS = 5;
  localparam int XW    = (X_NODES > 1) ? $clog2(X_NODES) : 1;
  localparam int YW    = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] PL = 3'd0;
  localparam logic [2:0] PN = 3'd1;
  localparam logic [2:0] PE = 3'd2;
  localparam logic [2:0] PS = 3'd3;
  localparam logic [2:0] PW = 3'd4;

  logic [FIFO_WIDTH-1:0] fifoMem   [NODES][PORTS][FIFO_DEPTH];
  logic [AW-1:0]         rdPtr     [NODES][PORTS];
  logic [AW-1:0]         wrPtr     [NODES][PORTS];
  logic [CW-1:0]         fifoCount [NODES][PORTS];
  logic [2:0]            rrPtr     [NODES][PORTS];
  logic [FIFO_WIDTH-1:0] ejectData [NODES];
  logic                  ejectValid[NODES];

  logic [FIFO_WIDTH-1:0] headData  [NODES][PORTS];
  logic                  headValid [NODES][PORTS];
  logic [2:0]            headRoute [NODES][PORTS];
  logic                  isFull    [NODES][PORTS];
  logic                  outValid  [NODES][PORTS];
  logic [FIFO_WIDTH-1:0] outData   [NODES][PORTS];
  logic [2:0]            winner    [NODES][PORTS];
  logic                  pop       [NODES][PORTS];
  logic                  push      [NODES][PORTS];
  logic [FIFO_WIDTH-1:0] pushData  [NODES][PORTS];

  function automatic logic [2:0] routeOf(input logic [XW-1:0] destX, input logic [YW-1:0] destY,
                                         input int x, input int y);
    int dx, dy, fwd;
    logic [2:0] dir;
    dx  = int'(destX) % X_NODES;
    dy  = int'(destY) % Y_NODES;
    fwd = 0;
    dir = PL;
    if (dx != x) begin
      fwd = (dx - x + X_NODES) % X_NODES;
      if (MODE == 1) dir = (2 * fwd <= X_NODES) ? PE : PW;
      else           dir = (dx > x) ? PE : PW;
    end else if (dy != y) begin
      fwd = (dy - y + Y_NODES) % Y_NODES;
      if (MODE == 1) dir = (2 * fwd <= Y_NODES) ? PS : PN;
      else           dir = (dy > y) ? PS : PN;
    end
    return dir;
  endfunction

  // Node reached through output dir, or -1 where a mesh edge has no link.
  function automatic int neighbour(input int n, input logic [2:0] dir);
    int nx, ny, result;
    nx = n % X_NODES;
    ny = n / X_NODES;
    case (dir)
      PN:      ny = ny - 1;
      PE:      nx = nx + 1;
      PS:      ny = ny + 1;
      PW:      nx = nx - 1;
      default: ;
    endcase
    if (MODE == 1) begin
      nx = (nx + X_NODES) % X_NODES;
      ny = (ny + Y_NODES) % Y_NODES;
    end
    if (nx < 0 || nx >= X_NODES || ny < 0 || ny >= Y_NODES) result = -1;
    else result = ny * X_NODES + nx;
    return result;
  endfunction

  function automatic logic [2:0] opposite(input logic [2:0] dir);
    case (dir)
      PN:      return PS;
      PS:      return PN;
      PE:      return PW;
      PW:      return PE;
      default: return PL;
    endcase
  endfunction

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    logic [FIFO_WIDTH-1:0] h;
    h = '0;
    for (int n = 0; n < NODES; n++) begin
      for (int q = 0; q < PORTS; q++) begin
        h               = fifoMem[n][q][rdPtr[n][q]];
        headData[n][q]  = h;
        headValid[n][q] = (fifoCount[n][q] != '0);
        isFull[n][q]    = (fifoCount[n][q] == CW'(FIFO_DEPTH));
        headRoute[n][q] = routeOf(h[FIFO_WIDTH-2 -: XW], h[FIFO_WIDTH-2-XW -: YW],
                                  n % X_NODES, n / X_NODES);
      end
    end
  end

  // Downstream fullness is this cycle's state, so a full FIFO never takes a flit even if it pops.
  always_comb begin
    int m;
    int cand;
    logic canSend;
    m = 0;
    cand = 0;
    canSend = 1'b0;
    for (int n = 0; n < NODES; n++)
      for (int q = 0; q < PORTS; q++) pop[n][q] = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      for (int o = 0; o < PORTS; o++) begin
        outValid[n][o] = 1'b0;
        outData[n][o]  = '0;
        winner[n][o]   = PL;
        canSend        = 1'b0;
        if (3'(o) == PL) begin
          canSend = !bus.nodeToNetworkHoldRequest[n];
        end else begin
          m = neighbour(n, 3'(o));
          if (m >= 0) canSend = !isFull[m][opposite(3'(o))];
        end
        for (int k = 0; k < PORTS; k++) begin
          cand = (int'(rrPtr[n][o]) + k) % PORTS;
          if (canSend && !outValid[n][o] && headValid[n][cand] && headRoute[n][cand] == 3'(o)) begin
            outValid[n][o] = 1'b1;
            outData[n][o]  = headData[n][cand];
            winner[n][o]   = 3'(cand);
            pop[n][cand]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    int m;
    m = 0;
    for (int n = 0; n < NODES; n++) begin
      for (int q = 0; q < PORTS; q++) begin
        push[n][q]     = 1'b0;
        pushData[n][q] = '0;
      end
    end
    for (int n = 0; n < NODES; n++) begin
      if (bus.nodeToNetworkWriteRequest[n] && !isFull[n][PL]) begin
        push[n][PL]     = 1'b1;
        pushData[n][PL] = bus.nodeToNetworkData[n];
      end
    end
    for (int n = 0; n < NODES; n++) begin
      for (int o = 1; o < PORTS; o++) begin
        m = neighbour(n, 3'(o));
        if (m >= 0 && outValid[n][o]) begin
          push[m][opposite(3'(o))]     = 1'b1;
          pushData[m][opposite(3'(o))] = outData[n][o];
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      bus.networkToNodeData[n]         = ejectData[n];
      bus.networkToNodeWriteRequest[n] = ejectValid[n];
      bus.networkToNodeHoldRequest[n]  = isFull[n][PL];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < NODES; n++) begin
        ejectValid[n] <= 1'b0;
        ejectData[n]  <= '0;
        for (int q = 0; q < PORTS; q++) begin
          rdPtr[n][q]     <= '0;
          wrPtr[n][q]     <= '0;
          fifoCount[n][q] <= '0;
          rrPtr[n][q]     <= PL;
        end
      end
    end else begin
      for (int n = 0; n < NODES; n++) begin
        ejectValid[n] <= outValid[n][PL];
        if (outValid[n][PL]) ejectData[n] <= outData[n][PL];
        for (int q = 0; q < PORTS; q++) begin
          if (push[n][q]) begin
            fifoMem[n][q][wrPtr[n][q]] <= pushData[n][q];
            wrPtr[n][q] <= nextPtr(wrPtr[n][q]);
          end
          if (pop[n][q]) rdPtr[n][q] <= nextPtr(rdPtr[n][q]);
          if (push[n][q] && !pop[n][q])      fifoCount[n][q] <= fifoCount[n][q] + CW'(1);
          else if (!push[n][q] && pop[n][q]) fifoCount[n][q] <= fifoCount[n][q] - CW'(1);
          if (outValid[n][q]) rrPtr[n][q] <= (winner[n][q] == PW) ? PL : winner[n][q] + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_network_torus.sv
// Scoreboard bench for network_torus: a 3x3 torus and a 3x3 mesh run side by side,
// expected deliveries (slot, data, cycle) are queued at injection and popped by a monitor.
module tb_network_torus;
  localparam int NODES = 9;
  localparam int WIDTH = 32;

  typedef struct packed {
    int               slot;
    logic [WIDTH-1:0] data;
    int               cycle;
  } expT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int compared = 0;
  int failed = 0;
  int bpCount = 0;
  expT expQ[$];
  logic [WIDTH-1:0] bpFlit [12];

  network_torus_if #(.NODES(NODES), .WIDTH(WIDTH)) torusBus ();
  network_torus_if #(.NODES(NODES), .WIDTH(WIDTH)) meshBus ();

  network_torus #(.X_NODES(3), .Y_NODES(3), .FIFO_WIDTH(WIDTH), .FIFO_DEPTH(4), .MODE(1))
    torusDut (.clk(clk), .reset(reset), .bus(torusBus));
  network_torus #(.X_NODES(3), .Y_NODES(3), .FIFO_WIDTH(WIDTH), .FIFO_DEPTH(4), .MODE(0))
    meshDut (.clk(clk), .reset(reset), .bus(meshBus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] mkFlit(input logic top, input logic [1:0] x,
                                              input logic [1:0] y, input logic [26:0] payload);
    return {top, x, y, payload};
  endfunction

  task automatic checkOutput(input string name, input int node,
                             input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] required);
    compared++;
    if (actual !== required) begin
      failed++;
      $display("[TB] FAIL %s node %0d: got %h, expected %h", name, node, actual, required);
    end
  endtask

  // Called just after a negedge; the flit is written at the next rising edge k and
  // must appear at the destination after edge k + latency.
  task automatic applyStimulus(input int dut, input int src, input logic [WIDTH-1:0] flit,
                               input int dst, input int latency);
    if (dut == 0) begin
      torusBus.nodeToNetworkWriteRequest[src] = 1'b1;
      torusBus.nodeToNetworkData[src]         = flit;
    end else begin
      meshBus.nodeToNetworkWriteRequest[src] = 1'b1;
      meshBus.nodeToNetworkData[src]         = flit;
    end
    expQ.push_back('{slot: dut * NODES + dst, data: flit, cycle: cyc + 1 + latency});
  endtask

  task automatic clearInputs();
    for (int n = 0; n < NODES; n++) begin
      torusBus.nodeToNetworkWriteRequest[n] = 1'b0;
      torusBus.nodeToNetworkData[n]         = '0;
      meshBus.nodeToNetworkWriteRequest[n]  = 1'b0;
      meshBus.nodeToNetworkData[n]          = '0;
    end
  endtask

  task automatic monitor();
    logic wr;
    logic [WIDTH-1:0] d;
    int idx;
    expT e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2 * NODES; s++) begin
        if (s < NODES) begin
          wr = torusBus.networkToNodeWriteRequest[s];
          d  = torusBus.networkToNodeData[s];
        end else begin
          wr = meshBus.networkToNodeWriteRequest[s - NODES];
          d  = meshBus.networkToNodeData[s - NODES];
        end
        if (wr === 1'b1) begin
          idx = -1;
          for (int j = 0; j < expQ.size(); j++)
            if (idx < 0 && expQ[j].slot == s) idx = j;
          if (idx < 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL unexpected delivery slot %0d: got %h, expected no delivery", s, d);
          end else begin
            e = expQ[idx];
            expQ.delete(idx);
            checkOutput("delivered data", s, d, e.data);
            checkOutput("delivery cycle", s, cyc, e.cycle);
          end
        end
      end
    end
  endtask

  initial begin
    clearInputs();
    for (int n = 0; n < NODES; n++) begin
      torusBus.nodeToNetworkHoldRequest[n] = 1'b0;
      meshBus.nodeToNetworkHoldRequest[n]  = 1'b0;
    end
    fork
      monitor();
    join_none

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < NODES; n++) begin
      checkOutput("torus reset writeRequest", n, 32'(torusBus.networkToNodeWriteRequest[n]), '0);
      checkOutput("torus reset holdRequest", n, 32'(torusBus.networkToNodeHoldRequest[n]), '0);
      checkOutput("torus reset data", n, torusBus.networkToNodeData[n], '0);
      checkOutput("mesh reset writeRequest", n, 32'(meshBus.networkToNodeWriteRequest[n]), '0);
      checkOutput("mesh reset holdRequest", n, 32'(meshBus.networkToNodeHoldRequest[n]), '0);
      checkOutput("mesh reset data", n, meshBus.networkToNodeData[n], '0);
    end
    reset = 1'b1;

    // Node 8 -> node 0: torus wraps East then South (2 hops), mesh goes 2 West + 2 North.
    @(negedge clk);
    applyStimulus(0, 8, 32'h81FF_FFFF, 0, 3);
    applyStimulus(1, 8, 32'h81FF_FFFF, 0, 5);
    @(negedge clk);
    clearInputs();
    repeat (8) @(negedge clk);

    // Node 0 -> node 8: torus wraps West then North, mesh goes 2 East + 2 South.
    applyStimulus(0, 0, mkFlit(1'b0, 2'd2, 2'd2, 27'h0123456), 8, 3);
    applyStimulus(1, 0, mkFlit(1'b0, 2'd2, 2'd2, 27'h0654321), 8, 5);
    @(negedge clk);
    clearInputs();
    repeat (8) @(negedge clk);

    // Self-addressed flit at node 4.
    applyStimulus(0, 4, mkFlit(1'b1, 2'd1, 2'd1, 27'h2A5A5A5), 4, 1);
    applyStimulus(1, 4, mkFlit(1'b1, 2'd1, 2'd1, 27'h15A5A5A), 4, 1);
    @(negedge clk);
    clearInputs();
    repeat (6) @(negedge clk);

    // Back-pressure: node 0 holds ejection while node 1 streams towards it.
    torusBus.nodeToNetworkHoldRequest[0] = 1'b1;
    bpCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (torusBus.networkToNodeHoldRequest[1] === 1'b0) begin
        bpFlit[bpCount] = mkFlit(i[0], 2'd0, 2'd0, 27'(32'h100 + i));
        torusBus.nodeToNetworkWriteRequest[1] = 1'b1;
        torusBus.nodeToNetworkData[1]         = bpFlit[bpCount];
        bpCount++;
      end else begin
        torusBus.nodeToNetworkWriteRequest[1] = 1'b0;
      end
      @(negedge clk);
    end
    clearInputs();
    repeat (4) @(negedge clk);
    checkOutput("flits accepted before hold", 1, 32'(bpCount), 32'd8);
    checkOutput("holdRequest while blocked", 1, 32'(torusBus.networkToNodeHoldRequest[1]), 32'd1);
    torusBus.nodeToNetworkHoldRequest[0] = 1'b0;
    for (int j = 0; j < bpCount; j++)
      expQ.push_back('{slot: 0, data: bpFlit[j], cycle: cyc + 1 + j});
    @(negedge clk);
    checkOutput("holdRequest first drain cycle", 1, 32'(torusBus.networkToNodeHoldRequest[1]), 32'd1);
    @(negedge clk);
    checkOutput("holdRequest after source pop", 1, 32'(torusBus.networkToNodeHoldRequest[1]), 32'd0);
    repeat (10) @(negedge clk);

    // Contention: nodes 5 and 3 stream into node 4; Local output alternates East/West inputs.
    for (int j = 0; j < 3; j++) begin
      applyStimulus(0, 5, mkFlit(1'b0, 2'd1, 2'd1, 27'(32'h500 + j)), 4, 2 + j);
      applyStimulus(0, 3, mkFlit(1'b1, 2'd1, 2'd1, 27'(32'h300 + j)), 4, 3 + j);
      @(negedge clk);
    end
    clearInputs();
    repeat (10) @(negedge clk);

    // Reset while a flit is in flight: it must never be delivered.
    torusBus.nodeToNetworkWriteRequest[8] = 1'b1;
    torusBus.nodeToNetworkData[8]         = 32'h81FF_FFFF;
    @(negedge clk);
    clearInputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("holdRequest after mid-run reset", 8, 32'(torusBus.networkToNodeHoldRequest[8]), '0);

    for (int t = 0; t < 40 && expQ.size() != 0; t++) @(negedge clk);
    checkOutput("scoreboard drained", 0, 32'(expQ.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
